// File: rtl/dmem_acc.sv
// rtl/dmem_acc.sv - hvcore data-memory access stage: loads, word stores, byte/half read-modify-write stores
module dmem_acc #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_rdata_valid_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        dmem_en_o,
    output logic        dmem_wr_o
);

    typedef enum logic [2:0] {
        IDLE, ST_WR, LD_REQ, LD_WAIT, RMW_REQ, RMW_WAIT, RMW_WR, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] st_data_q, st_data_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        dmem_en_q, dmem_en_d;
    logic        dmem_wr_q, dmem_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned;

`ifdef DMEM_ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        res = w;
        if (size == 2'b00) begin
            sh  = w >> {off, 3'b000};
            res = {{24{sgn & sh[7]}}, sh[7:0]};
        end else if (size == 2'b01) begin
            sh  = w >> {off[1], 4'b0000};
            res = {{16{sgn & sh[15]}}, sh[15:0]};
        end
        return res;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] lane;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            lane = {24'd0, d[7:0]} << {off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            lane = {16'd0, d} << {off[1], 4'b0000};
        end
        return (w & ~mask) | lane;
    endfunction

    assign misaligned = (size_i == 2'b11) ||
                        (size_i == 2'b01 && addr_i[0]) ||
                        (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        st_data_d    = st_data_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = 32'd0;
        dmem_en_d    = 1'b0;
        dmem_wr_d    = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        load_data_d  = load_data_q;
`ifdef DMEM_ACC_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    size_d      = size_i;
                    signed_d    = signed_i;
                    off_d       = addr_i[1:0];
                    st_data_d   = wdata_i[15:0];
                    dmem_addr_d = {addr_i[31:2], 2'b00};
                    if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (wr_i && size_i == 2'b10) begin
                        state_d      = ST_WR;
                        dmem_en_d    = 1'b1;
                        dmem_wr_d    = 1'b1;
                        dmem_wdata_d = wdata_i;
                    end else if (!wr_i) begin
                        state_d   = LD_REQ;
                        dmem_en_d = 1'b1;
                    end else begin
                        state_d   = RMW_REQ;
                        dmem_en_d = 1'b1;
                    end
                end
            end
            ST_WR, RMW_WR: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            LD_REQ: begin
                state_d = LD_WAIT;
`ifdef DMEM_ACC_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            LD_WAIT: begin
                if (dmem_rdata_valid_i) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    load_data_d = extract(dmem_rdata_i, size_q, off_q, signed_q);
`ifdef DMEM_ACC_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RMW_REQ: begin
                state_d = RMW_WAIT;
`ifdef DMEM_ACC_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RMW_WAIT: begin
                if (dmem_rdata_valid_i) begin
                    state_d      = RMW_WR;
                    dmem_en_d    = 1'b1;
                    dmem_wr_d    = 1'b1;
                    dmem_wdata_d = merge(dmem_rdata_i, st_data_q, size_q, off_q);
`ifdef DMEM_ACC_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            st_data_q    <= 16'd0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_en_q    <= 1'b0;
            dmem_wr_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_data_q  <= 32'd0;
`ifdef DMEM_ACC_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            st_data_q    <= st_data_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_en_q    <= dmem_en_d;
            dmem_wr_q    <= dmem_wr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            load_data_q  <= load_data_d;
`ifdef DMEM_ACC_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign stall_o      = (state_q == IDLE && req_i) || (state_q != IDLE && state_q != DONE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign load_data_o  = load_data_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign dmem_en_o    = dmem_en_q;
    assign dmem_wr_o    = dmem_wr_q;

endmodule

// File: tb/tb_dmem_acc.sv
// tb/tb_dmem_acc.sv - scoreboard bench for dmem_acc
module tb_dmem_acc;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        wr_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] load_data_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_rdata_valid_i;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_en_o;
    logic        dmem_wr_o;

    dmem_acc #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_i              (req_i),
        .wr_i               (wr_i),
        .size_i             (size_i),
        .signed_i           (signed_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .stall_o            (stall_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .load_data_o        (load_data_o),
        .dmem_rdata_i       (dmem_rdata_i),
        .dmem_rdata_valid_i (dmem_rdata_valid_i),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_en_o          (dmem_en_o),
        .dmem_wr_o          (dmem_wr_o)
    );

    typedef struct {
        logic        err;
        logic        chk_ld;
        logic [31:0] ld;
        int          lat;
    } done_exp_t;

    typedef struct {
        logic [31:0] wdata;
        int          lat;
    } wr_exp_t;

    done_exp_t   done_q[$];
    wr_exp_t     wr_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          strobes = 0;
    logic [31:0] cur_addr = 32'd0;
    int          resp_k  = 0;
    logic [31:0] resp_rdata = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int pend;
        pend = 0;
        dmem_rdata_valid_i = 1'b0;
        dmem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (dmem_en_o && !dmem_wr_o && resp_k > 0) pend = resp_k;
            @(posedge clk);
            #1;
            dmem_rdata_valid_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dmem_rdata_valid_i = 1'b1;
                    dmem_rdata_i = resp_rdata;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && dmem_en_o) begin
            strobes++;
            check("strobe_addr", dmem_addr_o, cur_addr);
            if (dmem_wr_o) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("write_data", dmem_wdata_o, w.wdata);
                    check("write_latency", cyc - acc_cyc, w.lat);
                end
            end else begin
                check("read_wdata_zero", dmem_wdata_o, 32'd0);
            end
        end
        if (!rst && done_o) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                check("done_err", {31'd0, err_o}, {31'd0, d.err});
                check("done_latency", cyc - acc_cyc, d.lat);
                if (d.chk_ld) check("load_data", load_data_o, d.ld);
                if (!d.err) check("addr_held", dmem_addr_o, cur_addr);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int k,
                         input logic exp_err, input logic chk_ld, input logic [31:0] exp_ld,
                         input int done_lat, input int wr_lat, input logic [31:0] wr_data,
                         input int nstrobe);
        done_exp_t d;
        wr_exp_t   w;
        int        s0;
        logic      got;
        @(posedge clk);
        #1;
        resp_k     = k;
        resp_rdata = rdata;
        req_i      = 1'b1;
        wr_i       = wr;
        size_i     = size;
        signed_i   = sgn;
        addr_i     = addr;
        wdata_i    = wdata;
        acc_cyc    = cyc;
        cur_addr   = {addr[31:2], 2'b00};
        s0         = strobes;
        d.err = exp_err; d.chk_ld = chk_ld; d.ld = exp_ld; d.lat = done_lat;
        done_q.push_back(d);
        if (wr_lat >= 0) begin
            w.wdata = wr_data; w.lat = wr_lat;
            wr_q.push_back(w);
        end
        @(negedge clk);
        check("stall_c0", {31'd0, stall_o}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done_o) got = 1'b1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        else check("stall_at_done", {31'd0, stall_o}, 32'd0);
        req_i = 1'b0;
        check("strobe_count", strobes - s0, nstrobe);
    endtask

    initial begin
        logic any_done;
        rst = 1'b1;
        req_i = 1'b0; wr_i = 1'b0; size_i = 2'b00; signed_i = 1'b0;
        addr_i = 32'd0; wdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {dmem_en_o, dmem_wr_o, done_o, err_o, stall_o}, 32'd0);
        check("rst_load_data", load_data_o, 32'd0);
        check("rst_addr", dmem_addr_o | dmem_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h8899AABB, 1, 1'b0, 1'b1, 32'h8899AABB, 3, -1, 32'h0,        1);
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 1'b1, 32'hFFFFFF80, 3, -1, 32'h0,        1);
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 1'b1, 32'h00000080, 3, -1, 32'h0,        1);
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234,     32'hAAAABBBB, 1, 1'b0, 1'b1, 32'h00000080, 4,  3, 32'h1234BBBB, 2);
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0,        1, 1'b0, 1'b1, 32'h00000080, 2,  1, 32'hDEADBEEF, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h401, 32'hFFFFFF5A, 32'h11223344, 2, 1'b0, 1'b0, 32'h0,        5,  4, 32'h11225A44, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h106, 32'h0,        32'h9ABC0000, 3, 1'b0, 1'b1, 32'hFFFF9ABC, 5, -1, 32'h0,        1);
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'h0000C300, 1, 1'b0, 1'b1, 32'h000000C3, 3, -1, 32'h0,        1);
        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        1, 1'b1, 1'b1, 32'h000000C3, 1, -1, 32'h0,        0);
        issue(1'b1, 2'b01, 1'b0, 32'h203, 32'h5555,     32'h0,        1, 1'b1, 1'b0, 32'h0,        1, -1, 32'h0,        0);
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1, 1'b1, 1'b1, 32'h000000C3, 1, -1, 32'h0,        0);

        @(posedge clk);
        #1;
        resp_k = 3; resp_rdata = 32'hFFFFFFFF;
        req_i = 1'b1; wr_i = 1'b0; size_i = 2'b10; signed_i = 1'b0; addr_i = 32'h500;
        cur_addr = 32'h500; acc_cyc = cyc;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        any_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_o) any_done = 1'b1;
        end
        check("rst_no_done", {31'd0, any_done}, 32'd0);
        check("rst_mid_load_data", load_data_o, 32'd0);
        check("rst_mid_idle", {31'd0, stall_o}, 32'd0);

`ifdef DMEM_ACC_TIMEOUT_EN
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h12345678, 0, 1'b1, 1'b1, 32'h0, 6, -1, 32'h0, 1);
`endif
        issue(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'hCAFEF00D, 1, 1'b0, 1'b1, 32'hCAFEF00D, 3, -1, 32'h0, 1);

        repeat (3) @(posedge clk);
        check("done_queue_empty", done_q.size(), 32'd0);
        check("write_queue_empty", wr_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
